hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard/forwarding controller for the 5-stage 19-bit MIPS-style core; owns the datapath's "flush" net.
//  Tracks in-flight writers in a 3-deep shadow pipeline (EX, MEM, WB) mirroring ID_EX/EX_MEM/MEM_WB.
//  Drives PC/IF_ID stall, IF_ID flush, ID_EX bubble and registered operand-forwarding selects; counts stall and flush events.
// PARAMETERS
//  RA_W     3   register address width
//  INST_W   19  instruction width
//  CNT_W    16  width of the saturating stall/flush counters
// PORTS
//  clk            in   1       core clock; all state updates on posedge
//  reset          in   1       asynchronous, active-high reset
//  id_instruction in   INST_W  IF_ID instruction: srcA=[10:8], srcB=[7:5] or [13:11], dest=[13:11]
//  id_valid       in   1       ID holds a real instruction (0 after flush/reset)
//  id_reg_b_sel   in   1       0: srcB=[7:5], 1: srcB=[13:11] (same as reg_B_mux)
//  id_uses_a      in   1       ID instruction reads srcA
//  id_uses_b      in   1       ID instruction reads srcB
//  id_reg_write   in   1       ID instruction writes dest
//  id_is_load     in   1       ID instruction's writeback source is data memory
//  id_writes_flags in  1       ID instruction writes C or Z
//  id_reads_flags in   1       ID instruction is a conditional branch on C/Z
//  id_pc_mux      in   2       controller PC select; !=2'b00 means redirect
//  stall_pc       out  1       hold PC
//  stall_if_id    out  1       hold IF_ID
//  flush_if_id    out  1       clear IF_ID (datapath "flush")
//  bubble_id_ex   out  1       load NOP controls into ID_EX
//  fwd_a          out  2       EX operand A select: 00 regfile, 10 EX_MEM alu_out, 11 WB data
//  fwd_b          out  2       EX operand B select, same encoding (datapath maps into alu_in_mux)
//  stall_cnt      out  CNT_W   stall cycles, saturating
//  flush_cnt      out  CNT_W   flushes, saturating
// BEHAVIOUR
//  Reset: shadow stages invalid, fwd_a=fwd_b=00, counters 0; combinational outputs then evaluate to 0 for id_valid=0.
//  Shadow entry {valid,dest,reg_write,is_load,writes_flags}; each posedge: WB<=MEM, MEM<=EX, EX<=(stall|!id_valid)?0:ID fields.
//  Hazards (combinational, only when id_valid; a match needs shadow valid & reg_write & dest==src & src used):
//   load_use : EX entry is_load and matches srcA/srcB.
//   wb_coll  : WB entry matches srcA/srcB (regfile write lands after the ID read).
//   flag_haz : id_reads_flags & EX entry valid & writes_flags.
//   stall = load_use|wb_coll|flag_haz -> stall_pc=stall_if_id=bubble_id_ex=1, exactly that cycle.
//  flush_if_id = id_valid & (id_pc_mux!=00) & !stall; one cycle per redirect.
//  Stall and redirect together: stall wins, flush suppressed; redirect re-evaluates next cycle.
//  Forwarding registered at posedge for the instruction entering EX (0 latency in its EX cycle):
//   src matches EX entry (non-load) -> 10; else matches MEM entry -> 11; else 00. Nearer stage wins.
//   On stall or !id_valid: fwd_a/fwd_b <= 00 (bubble).
//  Register 0 is an ordinary register; no zero-suppression on matches.
//  Counters: +1 per stall cycle / per flush cycle; hold at all-ones.
//  Reset mid-stall: async clear; the following cycle carries no stall from stale shadow state.
// STRUCTURE
//  hazard_pkg: FWD_REG=2'b00, FWD_EX_MEM=2'b10, FWD_WB=2'b11; field slices SRC_A, SRC_B_LO, SRC_B_HI, DEST; shadow entry struct.
//  Sub-module hazard_shadow_stage (one entry register with async reset and clear); instantiated 3x.
// TESTING
//  Load r2 in ID_EX, ID add reads r2 as srcA -> stall/bubble 1 cycle, then fwd_a=11 in add's EX.
//  add r3 then add using r3 as srcB (reg_b_sel=0) -> no stall, fwd_b=10; one instr gap -> fwd_b=11.
//  r4 written by both EX and MEM entries, ID reads r4 -> fwd=10 (nearest wins).
//  Flag-writing op in EX, conditional branch in ID with id_pc_mux=01 -> 1 stall, no flush; next cycle flush_if_id=1, flush_cnt=1.
//  JMP (id_pc_mux=10) with no hazard -> flush_if_id=1 one cycle, stall=0.
//  Assert reset during load-use stall -> all outputs 0 immediately; CNT_W=2 saturation: 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, field positions and match helper for the hazard unit
package hazard_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int INSTR_W    = 19;

    // Forwarding select encodings seen by the EX-stage operand muxes
    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [1:0] FWD_WB     = 2'b11;

    // LSB positions of the register fields inside an instruction word
    localparam int SRC_A    = 8;
    localparam int SRC_B_LO = 5;
    localparam int SRC_B_HI = 11;
    localparam int DEST     = 11;

    // One in-flight writer as tracked by the shadow pipeline
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  reg_write;
        logic                  is_load;
        logic                  writes_flags;
    } shadow_entry_t;

    // A shadow entry produces a source operand the ID instruction actually reads
    function automatic logic entry_matches(input shadow_entry_t e,
                                           input logic [REG_ADDR_W-1:0] src,
                                           input logic used);
        return e.valid & e.reg_write & (e.dest == src) & used;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// rtl/hazard_shadow_stage.sv - one shadow pipeline entry register with async reset and sync clear
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  shadow_entry_t entry_i,
    output shadow_entry_t entry_o
);

    shadow_entry_t entry_q;

    // Capture the upstream entry, or an empty slot when a bubble is inserted
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            entry_q <= '0;
        end else if (clear_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_i;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush/forwarding controller for the 5-stage core
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA_W   = REG_ADDR_W,
    parameter int INST_W = INSTR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [INST_W-1:0] id_instruction,
    input  logic              id_valid,
    input  logic              id_reg_b_sel,
    input  logic              id_uses_a,
    input  logic              id_uses_b,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              id_writes_flags,
    input  logic              id_reads_flags,
    input  logic [1:0]        id_pc_mux,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              bubble_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [RA_W-1:0] src_a;
    logic [RA_W-1:0] src_b;
    logic [RA_W-1:0] dest;
    logic            instr_unused;

    shadow_entry_t ex_d;
    shadow_entry_t ex_q;
    shadow_entry_t mem_q;
    shadow_entry_t wb_q;
    logic          shadow_unused;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic load_use, wb_coll, flag_haz, stall, flush;

    logic [1:0]       fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    assign src_a = id_instruction[SRC_A +: RA_W];
    assign src_b = id_reg_b_sel ? id_instruction[SRC_B_HI +: RA_W]
                                : id_instruction[SRC_B_LO +: RA_W];
    assign dest  = id_instruction[DEST +: RA_W];

    // Opcode and immediate bits carry no register information here
    assign instr_unused = ^{id_instruction[INST_W-1:14], id_instruction[4:0]};

    // Fields of the ID instruction as it would enter ID_EX
    always_comb begin
        ex_d              = '0;
        ex_d.valid        = 1'b1;
        ex_d.dest         = dest;
        ex_d.reg_write    = id_reg_write;
        ex_d.is_load      = id_is_load;
        ex_d.writes_flags = id_writes_flags;
    end

    hazard_shadow_stage u_ex (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (stall | ~id_valid),
        .entry_i (ex_d),
        .entry_o (ex_q)
    );

    hazard_shadow_stage u_mem (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (1'b0),
        .entry_i (ex_q),
        .entry_o (mem_q)
    );

    hazard_shadow_stage u_wb (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (1'b0),
        .entry_i (mem_q),
        .entry_o (wb_q)
    );

    // Load and flag bits of the later stages never influence a decision
    assign shadow_unused = ^{mem_q, wb_q};

    assign ex_hit_a  = entry_matches(ex_q,  src_a, id_uses_a);
    assign ex_hit_b  = entry_matches(ex_q,  src_b, id_uses_b);
    assign mem_hit_a = entry_matches(mem_q, src_a, id_uses_a);
    assign mem_hit_b = entry_matches(mem_q, src_b, id_uses_b);
    assign wb_hit_a  = entry_matches(wb_q,  src_a, id_uses_a);
    assign wb_hit_b  = entry_matches(wb_q,  src_b, id_uses_b);

    // Hazard detection; stall takes priority over a redirect in the same cycle
    always_comb begin
        load_use = ex_q.is_load & (ex_hit_a | ex_hit_b);
        wb_coll  = wb_hit_a | wb_hit_b;
        flag_haz = id_reads_flags & ex_q.valid & ex_q.writes_flags;
        stall    = id_valid & (load_use | wb_coll | flag_haz);
        flush    = id_valid & (id_pc_mux != 2'b00) & ~stall;
    end

    assign stall_pc     = stall;
    assign stall_if_id  = stall;
    assign bubble_id_ex = stall;
    assign flush_if_id  = flush;

    // Operand selects for the instruction about to enter EX; nearer producer wins
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (id_valid && !stall) begin
            if (ex_hit_a && !ex_q.is_load) begin
                fwd_a_d = FWD_EX_MEM;
            end else if (mem_hit_a) begin
                fwd_a_d = FWD_WB;
            end
            if (ex_hit_b && !ex_q.is_load) begin
                fwd_b_d = FWD_EX_MEM;
            end else if (mem_hit_b) begin
                fwd_b_d = FWD_WB;
            end
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Registered forwarding selects and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
